// File: rtl/bus_cycle_controller.sv
// -----------------------------------------------------------------------------
// bus_cycle_controller
//
// Sequences the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) of the
// 4-bit system bus and arbitrates ownership of the shared data bus. Each phase
// selects at most one driver (cpu, one ROM chip or one RAM chip) and raises
// the CM command strobes. The ROM chip number is captured from the bus in A3,
// and the SRC address is captured in X2/X3, so later I/O reads reach the right
// chip. A halt input freezes the machine in X3.
//
// Ports
//   clock        in   1         system clock, one phase per cycle
//   reset        in   1         synchronous, active-high
//   halt         in   1         sampled in X3; 1 = stay in X3
//   data_bus     in   4         snooped bus value for the current phase
//   src_cycle    in   1         current instruction is SRC (valid M2..X3)
//   io_cycle     in   1         current instruction is I/O group 0xE_ (M2..X3)
//   io_rom       in   1         I/O targets a ROM port, else a RAM chip
//   io_read      in   1         I/O reads memory onto the bus in X2
//   dcl_bank     in   3         RAM bank selected by the last DCL
//   phase        out  3         0=A1 .. 7=X3
//   sync         out  1         high while phase is X3
//   cpu_drive    out  1         cpu owns the bus this phase
//   rom_drive    out  NUM_ROMS  one-hot ROM bus enable
//   ram_drive    out  NUM_RAMS  one-hot RAM bus enable
//   cm_rom       out  1         ROM command strobe
//   cm_ram       out  8         per-bank RAM command strobe
//   fetch_miss   out  1         high in M1 when the A3 chip number has no ROM
//   bus_conflict out  1         sticky: more than one driver in one phase
// -----------------------------------------------------------------------------
module bus_cycle_controller #(
  parameter int NUM_ROMS = 2,
  parameter int NUM_RAMS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                halt,
  input  logic [3:0]          data_bus,
  input  logic                src_cycle,
  input  logic                io_cycle,
  input  logic                io_rom,
  input  logic                io_read,
  input  logic [2:0]          dcl_bank,
  output logic [2:0]          phase,
  output logic                sync,
  output logic                cpu_drive,
  output logic [NUM_ROMS-1:0] rom_drive,
  output logic [NUM_RAMS-1:0] ram_drive,
  output logic                cm_rom,
  output logic [7:0]          cm_ram,
  output logic                fetch_miss,
  output logic                bus_conflict
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  localparam logic [NUM_ROMS-1:0] ROM_ONE = NUM_ROMS'(1);
  localparam logic [NUM_RAMS-1:0] RAM_ONE = NUM_RAMS'(1);

  // State
  phase_e     phase_q,        phase_d;
  logic [3:0] rom_sel_q,      rom_sel_d;
  logic [3:0] src_hi_q,       src_hi_d;
  logic [3:0] src_lo_q,       src_lo_d;
  logic       bus_conflict_q, bus_conflict_d;

  // Decoded (ungated) phase outputs
  logic                cpu_c;
  logic [NUM_ROMS-1:0] rom_c;
  logic [NUM_RAMS-1:0] ram_c;
  logic                cm_rom_c;
  logic [7:0]          cm_ram_c;
  logic                fetch_miss_c;

  // Candidate targets
  logic [4:0]          ram_idx;
  logic [NUM_ROMS-1:0] rom_fetch;
  logic [NUM_ROMS-1:0] rom_io;
  logic [NUM_RAMS-1:0] ram_io;
  logic                rom_sel_ok;
  logic [7:0]          bank_strobe;

  // ---------------------------------------------------------------------------
  // Phase decode: outputs follow the phase register in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    cpu_c        = 1'b0;
    rom_c        = '0;
    ram_c        = '0;
    cm_rom_c     = 1'b0;
    cm_ram_c     = '0;
    fetch_miss_c = 1'b0;

    // RAM chip index is the bank extended by the top two SRC address bits.
    ram_idx     = {dcl_bank, src_hi_q[3:2]};
    rom_sel_ok  = int'(rom_sel_q) < NUM_ROMS;
    rom_fetch   = rom_sel_ok ? (ROM_ONE << rom_sel_q) : '0;
    rom_io      = (int'(src_hi_q) < NUM_ROMS) ? (ROM_ONE << src_hi_q) : '0;
    ram_io      = (int'(ram_idx) < NUM_RAMS) ? (RAM_ONE << ram_idx) : '0;
    bank_strobe = 8'b1 << dcl_bank;

    case (phase_q)
      PH_A1, PH_A2: cpu_c = 1'b1;
      PH_A3: begin
        cpu_c    = 1'b1;
        cm_rom_c = 1'b1;
        cm_ram_c = bank_strobe;
      end
      PH_M1: begin
        rom_c        = rom_fetch;
        fetch_miss_c = !rom_sel_ok;
      end
      PH_M2: begin
        rom_c = rom_fetch;
        if (io_cycle) begin
          cm_rom_c = 1'b1;
          cm_ram_c = bank_strobe;
        end
      end
      PH_X2: begin
        // SRC takes priority over I/O when both decode bits are set.
        if (src_cycle) begin
          cpu_c    = 1'b1;
          cm_rom_c = 1'b1;
          cm_ram_c = bank_strobe;
        end else if (io_cycle && io_read) begin
          if (io_rom) rom_c = rom_io;
          else        ram_c = ram_io;
        end else if (io_cycle) begin
          cpu_c = 1'b1;
        end
      end
      PH_X3: cpu_c = src_cycle && !halt;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d        = phase_e'(phase_q + 3'd1);
    rom_sel_d      = rom_sel_q;
    src_hi_d       = src_hi_q;
    src_lo_d       = src_lo_q;
    bus_conflict_d = bus_conflict_q || ($countones({cpu_c, rom_c, ram_c}) > 1);

    if (phase_q == PH_X3) phase_d = halt ? PH_X3 : PH_A1;
    if (phase_q == PH_A3) rom_sel_d = data_bus;
    if (phase_q == PH_X2 && src_cycle) src_hi_d = data_bus;
    // Low nibble is captured only when X3 actually ends.
    if (phase_q == PH_X3 && src_cycle && !halt) src_lo_d = data_bus;
  end

  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      phase_q        <= PH_A1;
      rom_sel_q      <= '0;
      src_hi_q       <= '0;
      src_lo_q       <= '0;
      bus_conflict_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      rom_sel_q      <= rom_sel_d;
      src_hi_q       <= src_hi_d;
      src_lo_q       <= src_lo_d;
      bus_conflict_q <= bus_conflict_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: everything reads zero while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    phase        = reset ? 3'd0 : phase_q;
    sync         = !reset && (phase_q == PH_X3);
    cpu_drive    = !reset && cpu_c;
    rom_drive    = reset ? '0 : rom_c;
    ram_drive    = reset ? '0 : ram_c;
    cm_rom       = !reset && cm_rom_c;
    cm_ram       = reset ? '0 : cm_ram_c;
    fetch_miss   = !reset && fetch_miss_c;
    bus_conflict = !reset && bus_conflict_q;
  end

endmodule
